// File: rtl/dmix_pkg.sv
// Shared types and constants for the DAC feed scheduler.
package dmix_pkg;

  localparam int DW_DEF = 24;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous per-channel sample FIFO with show-ahead head word.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sample_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_dout,
  output logic          o_empty,
  output logic          o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_rd;
  logic          w_do_wr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  // A read in the same cycle frees a slot, so a write to a full FIFO is kept then.
  assign w_do_rd = i_rd_en & ~o_empty;
  assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/dac_feed_sched.sv
// Sample scheduler between mixer and dac_drv: per-channel FIFOs, pop arbitration, underrun fill.
// Define DMIX_UNDERRUN_HOLD_EN to repeat the last delivered sample on underrun instead of silence.
module dac_feed_sched
  import dmix_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en_i,
  input  logic            wr_ch_i,
  input  logic [DW-1:0]   wr_data_i,
  output logic [1:0]      full_o,
  input  logic [1:0]      pop_i,
  output logic [DW-1:0]   data_o,
  output logic [1:0]      ack_o,
  output logic [1:0]      underrun_o,
  output logic [CNTW-1:0] urun_cnt_o,
  input  logic            clr_i,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a rising pop_i bit is one request; the matching ack_o bit is high
  // for exactly one cycle and data_o is valid from that cycle until the next ack.

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_pop;
  logic [1:0]      r_pending;
  logic [1:0]      w_rise;
  logic            r_rr;
  logic            r_ch;
  logic            w_grant;
  logic            w_sel;
  logic            w_serve;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_underrun;
  logic [CNTW-1:0] r_cnt;
  logic [DW-1:0]   w_dout [2];
  logic [1:0]      w_empty;
  logic [1:0]      w_fifo_wr;
  logic [1:0]      w_fifo_rd;
  logic [DW-1:0]   w_fill;
  logic [DW-1:0]   w_sample;
  logic            w_urun;

  assign w_rise = pop_i & ~r_pop;

  assign w_fifo_wr[0] = wr_en_i & (wr_ch_i == CH_L);
  assign w_fifo_wr[1] = wr_en_i & (wr_ch_i == CH_R);
  assign w_fifo_rd[0] = w_serve & (r_ch == CH_L);
  assign w_fifo_rd[1] = w_serve & (r_ch == CH_R);

  sample_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_l (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_fifo_wr[0]),
    .i_wr_data(wr_data_i),
    .i_rd_en  (w_fifo_rd[0]),
    .o_dout   (w_dout[0]),
    .o_empty  (w_empty[0]),
    .o_full   (full_o[0])
  );

  sample_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_r (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_fifo_wr[1]),
    .i_wr_data(wr_data_i),
    .i_rd_en  (w_fifo_rd[1]),
    .o_dout   (w_dout[1]),
    .o_empty  (w_empty[1]),
    .o_full   (full_o[1])
  );

`ifdef DMIX_UNDERRUN_HOLD_EN
  logic [DW-1:0] r_last [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last[0] <= '0;
      r_last[1] <= '0;
    end else if (w_serve) begin
      r_last[r_ch] <= w_sample;
    end
  end

  assign w_fill = r_last[r_ch];
`else
  assign w_fill = '0;
`endif

  assign w_urun   = w_serve & w_empty[r_ch];
  assign w_sample = w_empty[r_ch] ? w_fill : w_dout[r_ch];

  // The priority pointer only moves when both channels contend for the grant.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_sel       = r_ch;
    w_serve     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_grant     = 1'b1;
          w_sel       = (&r_pending) ? r_rr : r_pending[1];
          w_state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        w_serve     = 1'b1;
        w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pop     <= '0;
      r_pending <= '0;
      r_rr      <= CH_L;
      r_ch      <= CH_L;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pop     <= pop_i;
      r_pending <= (r_pending & ~(w_grant ? (w_sel ? 2'b10 : 2'b01) : 2'b00)) | w_rise;
      if (w_grant) begin
        r_ch <= w_sel;
        if (&r_pending) r_rr <= ~r_rr;
      end
      if (w_serve) r_data <= w_sample;
    end
  end

  // A clear in the same cycle as an underrun wins; that underrun is not recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= '0;
      r_cnt      <= '0;
    end else if (clr_i) begin
      r_underrun <= '0;
      r_cnt      <= '0;
    end else if (w_urun) begin
      r_underrun[r_ch] <= 1'b1;
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign data_o      = r_data;
  assign ack_o       = (r_state == ST_ACK) ? (r_ch ? 2'b10 : 2'b01) : 2'b00;
  assign underrun_o  = r_underrun;
  assign urun_cnt_o  = r_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dac_feed_sched.sv
// Bench for dac_feed_sched: queue-based reference model checked every cycle, plus directed scenarios.
module tb_dac_feed_sched;

  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int CNTW  = 16;
`ifdef DMIX_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en_i;
  logic            wr_ch_i;
  logic [DW-1:0]   wr_data_i;
  logic [1:0]      full_o;
  logic [1:0]      pop_i;
  logic [DW-1:0]   data_o;
  logic [1:0]      ack_o;
  logic [1:0]      underrun_o;
  logic [CNTW-1:0] urun_cnt_o;
  logic            clr_i;
  logic [1:0]      dbg_state_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dac_feed_sched #(.DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wr_ch_i    (wr_ch_i),
    .wr_data_i  (wr_data_i),
    .full_o     (full_o),
    .pop_i      (pop_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .underrun_o (underrun_o),
    .urun_cnt_o (urun_cnt_o),
    .clr_i      (clr_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel FIFO is a queue; a grant occupies the server for three edges:
  // grant, deliver (ack visible afterwards), release.
  logic [DW-1:0]   exp_q0[$];
  logic [DW-1:0]   exp_q1[$];
  logic [1:0]      m_pend;
  logic [1:0]      m_prev_pop;
  logic            m_pref;
  int              m_busy;
  logic            m_ch;
  logic [DW-1:0]   m_data;
  logic [DW-1:0]   m_last [2];
  logic [1:0]      m_ack;
  logic [1:0]      m_urun;
  logic [CNTW-1:0] m_cnt;

  always @(posedge clk) begin : model
    logic [1:0]    rise;
    logic [DW-1:0] s;
    bit            ur;
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      m_pend = 0; m_prev_pop = 0; m_pref = 0; m_busy = 0; m_ch = 0;
      m_data = 0; m_last[0] = 0; m_last[1] = 0; m_ack = 0; m_urun = 0; m_cnt = 0;
    end else begin
      rise = pop_i & ~m_prev_pop;
      m_prev_pop = pop_i;
      ur = 0;
      if (m_busy == 2) begin
        if ((m_ch ? exp_q1.size() : exp_q0.size()) == 0) begin
          s  = HOLD ? m_last[m_ch] : '0;
          ur = 1;
        end else begin
          s = m_ch ? exp_q1.pop_front() : exp_q0.pop_front();
        end
        m_data = s;
        m_last[m_ch] = s;
        m_ack = m_ch ? 2'b10 : 2'b01;
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_ack = 0;
        m_busy = 0;
      end else if (m_pend != 0) begin
        if (m_pend == 2'b11) begin
          m_ch = m_pref;
          m_pref = ~m_pref;
        end else begin
          m_ch = m_pend[1];
        end
        m_pend[m_ch] = 1'b0;
        m_busy = 2;
      end
      m_pend = m_pend | rise;
      if (wr_en_i) begin
        if (wr_ch_i == 1'b0 && exp_q0.size() < DEPTH) exp_q0.push_back(wr_data_i);
        if (wr_ch_i == 1'b1 && exp_q1.size() < DEPTH) exp_q1.push_back(wr_data_i);
      end
      if (clr_i) begin
        m_urun = 0;
        m_cnt = 0;
      end else if (ur) begin
        m_urun[m_ch] = 1'b1;
        if (m_cnt != {CNTW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("ack", 32'(ack_o), 32'(m_ack));
      chk("data", 32'(data_o), 32'(m_data));
      chk("full", 32'(full_o), {30'd0, exp_q1.size() == DEPTH, exp_q0.size() == DEPTH});
      chk("underrun", 32'(underrun_o), 32'(m_urun));
      chk("urun_cnt", 32'(urun_cnt_o), 32'(m_cnt));
      chk("ack_onehot", 32'($countones(ack_o) <= 1), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic ch, input logic [DW-1:0] d);
    wr_en_i = 1'b1; wr_ch_i = ch; wr_data_i = d;
    @(negedge clk);
    wr_en_i = 1'b0;
  endtask

  // Pulses pop_i for one cycle and returns the negedges until an ack is seen (99 = none).
  task automatic do_pop(input logic [1:0] mask, output int lat);
    bit seen;
    seen = 0;
    lat = 99;
    pop_i = mask;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      pop_i = 2'b00;
      if (ack_o != 2'b00) begin
        seen = 1;
        lat = i;
      end
    end
  endtask

  task automatic next_ack(output int lat);
    bit seen;
    seen = 0;
    lat = 99;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (ack_o != 2'b00) begin
        seen = 1;
        lat = i;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int acks;
    rst = 1'b1; wr_en_i = 0; wr_ch_i = 0; wr_data_i = '0; pop_i = 0; clr_i = 0;

    // Reset state, then reset in the middle of an ack.
    do_reset();
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_cnt", 32'(urun_cnt_o), 0);
    do_pop(2'b01, lat);
    chk("t1_urun_cnt", 32'(urun_cnt_o), 1);
    wr(0, 24'h000111);
    wr(0, 24'h000222);
    do_pop(2'b01, lat);
    chk("t1_ack_pre", 32'(ack_o), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_ack_rst", 32'(ack_o), 0);
    chk("t1_cnt_rst", 32'(urun_cnt_o), 0);
    chk("t1_urun_rst", 32'(underrun_o), 0);
    rst = 1'b0;
    @(negedge clk);
    do_pop(2'b01, lat);
    chk("t1_empty_after_rst", 32'(data_o), 0);
    chk("t1_urun_after_rst", 32'(underrun_o), 32'h1);

    // Single pop: three-cycle latency.
    do_reset();
    wr(0, 24'h123456);
    do_pop(2'b01, lat);
    chk("t2_lat", lat, 3);
    chk("t2_ack", 32'(ack_o), 32'h1);
    chk("t2_data", 32'(data_o), 32'h123456);
    @(negedge clk);
    chk("t2_ack_once", 32'(ack_o), 0);

    // Simultaneous pops and round-robin order.
    do_reset();
    wr(0, 24'hAAAA01);
    wr(1, 24'hBBBB02);
    do_pop(2'b11, lat);
    chk("t3_lat1", lat, 3);
    chk("t3_ack1", 32'(ack_o), 32'h1);
    chk("t3_data1", 32'(data_o), 32'hAAAA01);
    next_ack(lat);
    chk("t3_lat2", lat, 3);
    chk("t3_ack2", 32'(ack_o), 32'h2);
    chk("t3_data2", 32'(data_o), 32'hBBBB02);
    wr(0, 24'hCCCC03);
    wr(1, 24'hDDDD04);
    do_pop(2'b11, lat);
    chk("t3_ack3", 32'(ack_o), 32'h2);
    chk("t3_data3", 32'(data_o), 32'hDDDD04);
    next_ack(lat);
    chk("t3_ack4", 32'(ack_o), 32'h1);
    chk("t3_data4", 32'(data_o), 32'hCCCC03);

    // Underrun on R.
    do_reset();
    wr(1, 24'h5A5A5A);
    do_pop(2'b10, lat);
    chk("t4_data_e", 32'(data_o), 32'h5A5A5A);
    do_pop(2'b10, lat);
    chk("t4_ack", 32'(ack_o), 32'h2);
    chk("t4_fill", 32'(data_o), HOLD ? 32'h5A5A5A : 32'h0);
    chk("t4_urun", 32'(underrun_o), 32'h2);
    chk("t4_cnt", 32'(urun_cnt_o), 1);

    // Overfill L by one; drain in order.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      wr(0, 24'(32'h100 + i));
      if (i == DEPTH - 2) chk("t5_not_full", 32'(full_o), 0);
      if (i >= DEPTH - 1) chk("t5_full", 32'(full_o), 32'h1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_pop(2'b01, lat);
      chk("t5_order", 32'(data_o), 32'h100 + i);
    end
    chk("t5_drained", 32'(full_o), 0);
    do_pop(2'b01, lat);
    chk("t5_extra_dropped", 32'(data_o), HOLD ? 32'h107 : 32'h0);
    chk("t5_urun", 32'(underrun_o), 32'h1);

    // Held pop level gives a single ack; then clear.
    acks = 0;
    pop_i = 2'b01;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 9) pop_i = 2'b00;
      if (ack_o != 2'b00) acks++;
    end
    chk("t6_one_ack", acks, 1);
    chk("t6_cnt_pre", 32'(urun_cnt_o), 2);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    chk("t6_clr_urun", 32'(underrun_o), 0);
    chk("t6_clr_cnt", 32'(urun_cnt_o), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      wr_en_i   = ($urandom_range(0, 1) == 1);
      wr_ch_i   = 1'($urandom_range(0, 1));
      wr_data_i = 24'($urandom);
      if ($urandom_range(0, 3) == 0) pop_i[0] = ~pop_i[0];
      if ($urandom_range(0, 3) == 0) pop_i[1] = ~pop_i[1];
      clr_i = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    wr_en_i = 0; pop_i = 0; clr_i = 0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
